// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - prefetching instruction fetch unit; optional IFU_STALL_CNT_EN adds stall_cnt
module instr_fetch_unit #(
  parameter int AddrWidth  = 32,
  parameter int InstrWidth = 32,
  parameter int Depth      = 4,
  parameter logic [AddrWidth-1:0] ResetPC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [AddrWidth-1:0]  mem_addr,
  input  logic                  mem_ack,
  input  logic [InstrWidth-1:0] mem_rdata,
  output logic                  instr_valid,
  output logic [InstrWidth-1:0] instr,
  output logic [AddrWidth-1:0]  instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [AddrWidth-1:0]  redirect_pc
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                state, state_next;
  logic [AddrWidth-1:0]  fetch_pc, req_addr;
  logic [AddrWidth-1:0]  pc_mem  [Depth];
  logic [InstrWidth-1:0] ins_mem [Depth];
  logic [PtrW-1:0]       rd_ptr, wr_ptr;
  logic [CntW-1:0]       count, count_after;
  logic                  push, pop, issue;
  logic                  redirect_pc_unused;

  // Low address bits of a redirect target are forced to zero, never read.
  assign redirect_pc_unused = ^redirect_pc[1:0];

  assign mem_req     = (state == WAIT) || (state == DROP);
  assign mem_addr    = req_addr;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? ins_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : '0;

  // A redirect suppresses both the push of returning data and the pop by the core.
  assign push        = (state == WAIT) && mem_ack && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;
  assign count_after = count + CntW'(push) - CntW'(pop);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state and issue decision; a new request is only issued when a slot is guaranteed.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && (count < CntW'(Depth))) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_next = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          if (count_after < CntW'(Depth)) issue = 1'b1;
          else                            state_next = IDLE;
        end
      end
      DROP: begin
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetch address, occupancy and pointers; redirect flushes and retargets fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= ResetPC;
      req_addr <= ResetPC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[AddrWidth-1:2], 2'b00};
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      count <= count_after;
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      if (issue) begin
        req_addr <= fetch_pc;
        fetch_pc <= fetch_pc + AddrWidth'(4);
      end
    end
  end

  // FIFO storage: each entry pairs the returned word with the address it came from.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= req_addr;
      ins_mem[wr_ptr] <= mem_rdata;
    end
  end

`ifdef IFU_STALL_CNT_EN
  // Saturating count of cycles with no instruction offered, excluding redirect cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!instr_valid && !redirect && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef IFU_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] stall_model;
`endif

  int          total;
  int          bad;
  int          acks;
  int          pops;
  int          lat_mode;
  int          wcnt;
  int          cur_lat;
  bit          pend;
  logic [31:0] pend_addr;
  logic [31:0] exp_q[$];
  logic [31:0] plan_pc;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef IFU_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: sequential word addresses from the last redirect / reset target.
  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back(plan_pc);
      plan_pc = plan_pc + 32'd4;
    end
  endtask

  task automatic plan(input logic [31:0] start);
    exp_q.delete();
    plan_pc = {start[31:2], 2'b00};
    topup();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    redirect = 1'b0;
    plan(32'h0);
    acks = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_req(input int maxc, input string name);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      if (mem_req) break;
    end
    check(name, {31'd0, mem_req}, 32'd1);
  endtask

  // Memory responder: acks after a per-request latency, and checks the request stays put.
  always @(negedge clk) begin
    if (pend && rst) check("req_hold", {mem_req ? 32'd1 : 32'd0} ^ mem_addr, 32'd1 ^ pend_addr);
    if (!rst || !mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
      pend    = 1'b0;
    end else begin
      if (wcnt == 0) cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      if (wcnt >= cur_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_fn(mem_addr);
        wcnt      = 0;
        pend      = 1'b0;
        acks++;
      end else begin
        mem_ack   = 1'b0;
        wcnt++;
        pend      = 1'b1;
        pend_addr = mem_addr;
      end
    end
  end

  // Monitor: compares each consumed instruction against the scoreboard head.
  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
`ifdef IFU_STALL_CNT_EN
      stall_model = 32'd0;
`endif
    end else begin
      if (instr_valid && instr_ready && !redirect) begin
        pops++;
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'd0, 32'd1);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e);
          check("instr", instr, mem_fn(e));
        end
        topup();
      end
      if (!instr_valid) begin
        check("idle_instr", instr, 32'd0);
        check("idle_pc", instr_pc, 32'd0);
      end
`ifdef IFU_STALL_CNT_EN
      check("stall_cnt", stall_cnt, stall_model);
      if (!instr_valid && !redirect) stall_model = stall_model + 32'd1;
`endif
    end
  end

  initial begin
    int p0;
    bit hit;
    total = 0; bad = 0; acks = 0; pops = 0;
    pend = 1'b0; wcnt = 0; cur_lat = 0;
    rst = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0; lat_mode = 0;
`ifdef IFU_STALL_CNT_EN
    stall_model = 32'd0;
`endif
    plan(32'h0);
    #2;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
`ifdef IFU_STALL_CNT_EN
    check("rst_stall", stall_cnt, 32'd0);
`endif

    // Zero-wait memory, core always ready: one instruction per cycle.
    @(negedge clk);
    instr_ready = 1'b1;
    rst = 1'b1;
    #1 check("first_req_low", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h0);
    p0 = pops;
    repeat (20) @(negedge clk);
    check("throughput", pops - p0, 32'd18);

    // Core stalled: exactly Depth words fetched, then idle; refetch after first pop.
    instr_ready = 1'b0;
    lat_mode = 0;
    do_reset();
    repeat (10) @(negedge clk);
    check("fill_acks", acks, 32'd4);
    check("fill_req_idle", {31'd0, mem_req}, 32'd0);
    check("fill_valid", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    wait_req(5, "refill_req");
    check("refill_addr", mem_addr, 32'd16);

    // Redirect while a slow request is outstanding: its data must be dropped.
    lat_mode = 3;
    instr_ready = 1'b1;
    do_reset();
    wait_req(5, "drop_req0");
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    plan(32'h103);
    p0 = pops;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("drop_req_held", {31'd0, mem_req}, 32'd1);
    check("drop_addr_held", mem_addr, 32'h0);
    for (int i = 0; i < 10 && mem_req; i++) begin
      @(negedge clk);
      #1;
    end
    wait_req(5, "drop_req1");
    check("drop_next_addr", mem_addr, 32'h100);
    repeat (12) @(negedge clk);
    check("drop_progress", {31'd0, pops > p0}, 32'd1);

    // Redirect coinciding with mem_ack and a ready core: no push, no pop.
    lat_mode = 1;
    instr_ready = 1'b0;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (mem_ack && instr_valid) begin
        hit = 1'b1;
        break;
      end
    end
    check("rac_setup", {31'd0, hit}, 32'd1);
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h2000;
    plan(32'h2000);
    @(negedge clk);
    redirect = 1'b0;
    #1 check("rac_valid", {31'd0, instr_valid}, 32'd0);
    wait_req(5, "rac_req");
    check("rac_addr", mem_addr, 32'h2000);
    repeat (10) @(negedge clk);

    // Asynchronous reset with a request in flight.
    lat_mode = 5;
    instr_ready = 1'b0;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (mem_req && instr_valid) begin
        hit = 1'b1;
        break;
      end
    end
    check("ar_setup", {31'd0, hit}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("ar_req", {31'd0, mem_req}, 32'd0);
    check("ar_valid", {31'd0, instr_valid}, 32'd0);
    check("ar_pc", instr_pc, 32'd0);
    plan(32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lat_mode = 0;
    instr_ready = 1'b1;
    wait_req(5, "ar_restart_req");
    check("ar_restart_addr", mem_addr, 32'h0);

    // Ack delay 2 with a ready core (stall counter tracked continuously when present).
    lat_mode = 2;
    do_reset();
    repeat (30) @(negedge clk);

    // Randomized traffic: variable latency, ready and redirects.
    lat_mode = -1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect = 1'b1;
        redirect_pc = $urandom;
        plan(redirect_pc);
      end else begin
        redirect = 1'b0;
      end
    end
    @(negedge clk);
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
